// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC-driven reads from a synchronous instruction memory, buffered in a
// 2-entry FIFO for decode. Define IFU_ILLEGAL_HALT_EN to enable illegal-opcode detection and HALT.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic               busy,
  output logic               err,
  output logic [ADDR_W-1:0]  err_pc
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned FIFO_SZ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               outstanding;
  logic               valid1;
  logic [INSTR_W-1:0] entry1;
  logic               pop;
  logic               push;
  logic               illegal_ret;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               req_next;
  logic               busy_next;

`ifdef IFU_ILLEGAL_HALT_EN
  logic [ADDR_W-1:0]  req_addr;
  logic [OP_W-1:0]    ret_op;

  function automatic logic is_legal(input logic [OP_W-1:0] o);
    case (o)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  assign ret_op      = imem_rdata[INSTR_W-1 -: OP_W];
  assign illegal_ret = outstanding && (state == ST_RUN) && !is_legal(ret_op);
`else
  assign illegal_ret = 1'b0;
`endif

  // Returned data is only accepted while running; anything arriving in IDLE/HALT is dropped.
  assign pop        = instr_valid && instr_ready;
  assign push       = outstanding && (state == ST_RUN) && !illegal_ret;
  assign count      = CNT_W'(instr_valid) + CNT_W'(valid1);
  assign count_next = count - CNT_W'(pop) + CNT_W'(push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)       state_next = ST_RUN;
      ST_RUN:  if (illegal_ret) state_next = ST_HALT;
      ST_HALT:                  state_next = ST_HALT;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Next-cycle request/busy; the in-flight credit next cycle is this cycle's request.
  always_comb begin
    busy_next = (state_next == ST_RUN);
    req_next  = busy_next && ((count_next + CNT_W'(imem_req)) < CNT_W'(FIFO_SZ));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      outstanding <= 1'b0;
      imem_addr   <= ADDR_W'(RESET_PC);
    end else begin
      imem_req    <= req_next;
      busy        <= busy_next;
      outstanding <= imem_req;
      if (imem_req) begin
        imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end

  // Shift FIFO: instr is the head entry and keeps its last value once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      valid1      <= 1'b0;
      instr       <= '0;
      entry1      <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (valid1) begin
            instr  <= entry1;
            entry1 <= imem_rdata;
          end else begin
            instr  <= imem_rdata;
          end
        end
        2'b01: begin
          if (valid1) begin
            instr  <= entry1;
            valid1 <= 1'b0;
          end else begin
            instr_valid <= 1'b0;
          end
        end
        2'b10: begin
          if (!instr_valid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end else begin
            entry1 <= imem_rdata;
            valid1 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op = instr[INSTR_W-1 -: OP_W];

`ifdef IFU_ILLEGAL_HALT_EN
  // Address of each request is kept so an illegal return can report where it came from.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr <= '0;
      err      <= 1'b0;
      err_pc   <= '0;
    end else begin
      if (imem_req) begin
        req_addr <= imem_addr;
      end
      if (illegal_ret) begin
        err    <= 1'b1;
        err_pc <= req_addr;
      end
    end
  end
`else
  assign err    = 1'b0;
  assign err_pc = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model; honours
// IFU_ILLEGAL_HALT_EN the same way as the design.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned RESET_PC = 13;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
`ifdef IFU_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         op;
  logic               busy;
  logic               err;
  logic [ADDR_W-1:0]  err_pc;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Reference model state
  int                 m_state;
  int                 m_pc;
  bit                 m_out;
  int                 m_out_addr;
  logic [INSTR_W-1:0] m_fifo [$];
  logic [INSTR_W-1:0] m_head;
  bit                 m_err;
  int                 m_err_pc;
  int                 exp_addr;
  int                 req_cnt;
  int                 deliv_cnt;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op),
    .busy(busy), .err(err), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7};
  endfunction

  function automatic logic [INSTR_W-1:0] mk_word(input logic [5:0] o);
    return {o, 26'($urandom)};
  endfunction

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    if (allow_illegal && $urandom_range(0, 11) == 0) return 6'($urandom);
    case ($urandom_range(0, 5))
      0: return 6'd1;
      1: return 6'd2;
      2: return 6'd3;
      3: return 6'd4;
      4: return 6'd5;
      default: return 6'd7;
    endcase
  endfunction

  // Advances the model across one rising edge given the inputs sampled there.
  task automatic model_step(input bit rst_v, input bit start_v, input bit ready_v);
    bit                 req;
    logic [INSTR_W-1:0] w;
    if (!rst_v) begin
      m_state = 0; m_pc = RESET_PC; m_out = 0; m_out_addr = 0;
      m_fifo.delete(); m_head = '0; m_err = 0; m_err_pc = 0; exp_addr = RESET_PC;
      return;
    end
    req = (m_state == 1) && (m_fifo.size() + int'(m_out) < 2);
    if (m_fifo.size() > 0 && ready_v) void'(m_fifo.pop_front());
    if (m_out && m_state == 1) begin
      w = mem[m_out_addr];
      if (HALT_EN && !is_legal(w[INSTR_W-1 -: 6])) begin
        m_err = 1; m_err_pc = m_out_addr; m_state = 2;
      end else begin
        m_fifo.push_back(w);
      end
    end
    m_out = req;
    if (req) begin
      m_out_addr = m_pc;
      m_pc = (m_pc + 1) % DEPTH;
    end
    if (m_state == 0 && start_v) m_state = 1;
    if (m_fifo.size() > 0) m_head = m_fifo[0];
  endtask

  // Compare all outputs mid-cycle, then drive the inputs for the next edge.
  task automatic cycle(input bit rst_v, input bit start_v, input bit ready_v);
    @(negedge clk);
    check_eq("imem_req", imem_req, (m_state == 1) && (m_fifo.size() + int'(m_out) < 2));
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", instr_valid, m_fifo.size() != 0);
    check_eq("instr", instr, m_head);
    check_eq("op", op, m_head[INSTR_W-1 -: 6]);
    check_eq("busy", busy, m_state == 1);
    check_eq("err", err, m_err);
    check_eq("err_pc", err_pc, m_err_pc);
    if (rst_v && instr_valid && ready_v) begin
      check_eq("stream", instr, mem[exp_addr]);
      exp_addr = (exp_addr + 1) % DEPTH;
      deliv_cnt++;
    end
    if (rst_v && imem_req) req_cnt++;
    rst_n = rst_v; start = start_v; instr_ready = ready_v;
    model_step(rst_v, start_v, ready_v);
  endtask

  task automatic fill_mem(input bit allow_illegal);
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = mk_word(rand_op(allow_illegal));
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    req_cnt = 0;
    deliv_cnt = 0;
  endtask

  initial begin
    int lat;
    bit found;
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; imem_rdata = '0;
    fill_mem(1'b0);
    model_step(1'b0, 1'b0, 1'b0);

    // Ordered legal ops from the reset PC; first-instruction latency with ready held high.
    do_reset();
    mem[RESET_PC]           = mk_word(6'd1);
    mem[(RESET_PC+1)%DEPTH] = mk_word(6'd3);
    mem[(RESET_PC+2)%DEPTH] = mk_word(6'd5);
    mem[(RESET_PC+3)%DEPTH] = mk_word(6'd7);
    cycle(1'b1, 1'b1, 1'b1);
    lat = 0; found = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (!found && instr_valid) begin lat = k; found = 1; end
    end
    check_eq("first_latency", lat, 3);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 1'b1);
    check_eq("ordered_delivered", deliv_cnt >= 4, 1'b1);

    // Decoder stalled: only two requests may be issued.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("stall_reqs", req_cnt, 2);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1);

    // Opcode 6 at the third word; START pulses in RUN/HALT are ignored.
    cycle(1'b0, 1'b0, 1'b0);
    fill_mem(1'b0);
    mem[(RESET_PC+2)%DEPTH] = mk_word(6'd6);
    cycle(1'b0, 1'b0, 1'b0);
    req_cnt = 0; deliv_cnt = 0;
    cycle(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 14; k++) cycle(1'b1, k == 2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("halt_err", err, HALT_EN);
    if (HALT_EN) begin
      check_eq("halt_delivered", deliv_cnt, 2);
      check_eq("halt_err_pc", err_pc, (RESET_PC + 2) % DEPTH);
    end else begin
      check_eq("nohalt_delivered", deliv_cnt >= 3, 1'b1);
    end

    // Random traffic with stalls, restarts and mid-run resets.
    for (int s = 0; s < 40; s++) begin
      cycle(1'b0, 1'b0, 1'b0);
      fill_mem(1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, $urandom_range(0, 1) == 1);
      for (int k = 0; k < 60; k++) begin
        cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 7);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
